hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Pipeline hazard/stall controller for the pipelined RV32IM core. Detects load-use
//  hazards, sequences multi-cycle M-extension divides and squashes wrong-path
//  instructions after taken branches/jumps. Drives the select of the 9-bit ID/EX
//  control-bubble mux, the PC/IF-ID write enables and the IF-ID/ID-EX flushes.
// PARAMETERS
//  REG_W        5   register-index width
//  DIV_MAX_CYC  34  divide watchdog limit in cycles (DIV_BUSY cycles before abort)
//  CNT_W        16  width of stall performance counter
// PORTS
//  clk             in   1      core clock; sole clock
//  rst_n           in   1      reset; synchronous, active-low
//  ifid_rs1        in   REG_W  rs1 of instruction in ID
//  ifid_rs2        in   REG_W  rs2 of instruction in ID
//  ifid_use_rs1    in   1      ID instruction reads rs1
//  ifid_use_rs2    in   1      ID instruction reads rs2
//  idex_rd         in   REG_W  rd of instruction in EX
//  idex_memread    in   1      EX instruction is a load
//  ex_is_div       in   1      EX instruction is DIV/DIVU/REM/REMU
//  div_done        in   1      divider result valid (1-cycle pulse)
//  ex_redirect     in   1      taken branch/jump resolved in EX
//  pc_write        out  1      PC update enable
//  ifid_write      out  1      IF/ID register enable
//  ctrl_bubble_sel out  1      9-bit control mux select: 1 = zero controls into ID/EX
//  ifid_flush      out  1      clear IF/ID to NOP
//  ex_hold         out  1      hold ID/EX and EX stage
//  exmem_bubble    out  1      insert NOP into EX/MEM
//  div_start       out  1      1-cycle divider start pulse
//  div_err         out  1      1-cycle pulse: watchdog expired
//  stall_cnt       out  CNT_W  count of cycles with pc_write=0 (saturating)
// BEHAVIOUR
//  Reset: one clock; reset is synchronous and active-low. While rst_n=0 at a
//   clk edge: state<=RUN, wdog<=0, stall_cnt<=0. Outputs combinational from state+
//   inputs, but forced while rst_n=0: pc_write=0, ifid_write=0,
//   ctrl_bubble_sel=1, ifid_flush=1, ex_hold=0, exmem_bubble=1, div_start=0, div_err=0.
//  lu_haz = idex_memread & idex_rd!=0 & ((ifid_use_rs1 & rs1==rd)|(ifid_use_rs2 & rs2==rd)).
//  States: RUN, DIV_BUSY. Priority within a cycle: redirect > div > load-use.
//  RUN, ex_redirect=1: ifid_flush=1, ctrl_bubble_sel=1, pc_write=1; lu_haz ignored;
//   ex_is_div ignored (redirecting instr is not a div). Stay RUN.
//  RUN, ex_is_div=1: div_start=1, pc_write=0, ifid_write=0, ex_hold=1,
//   exmem_bubble=1; wdog<=0; next DIV_BUSY.
//  RUN, lu_haz=1 (no redirect/div): pc_write=0, ifid_write=0, ctrl_bubble_sel=1 for
//   exactly that cycle; stall self-clears as load advances to MEM.
//  RUN, none: pc_write=ifid_write=1, all else 0.
//  DIV_BUSY: pc_write=0, ifid_write=0, ex_hold=1, exmem_bubble=1, wdog<=wdog+1.
//   div_done=1: ex_hold=0, exmem_bubble=0 (result enters EX/MEM), pc_write=0,
//   ifid_write=0 still; next RUN. The div is released from EX, so ex_is_div=1 on
//   the following RUN cycle belongs to a new instruction and starts a new divide.
//   wdog==DIV_MAX_CYC-1 & !div_done: div_err=1, ex_hold=0, exmem_bubble=1 (div
//   squashed); next RUN. div_done and wdog limit same cycle: done wins, no err.
//   lu_haz and ex_redirect ignored in DIV_BUSY (the div occupies EX).
//  stall_cnt: +1 each cycle with pc_write=0 and rst_n=1; saturates at all-ones.
//  Reset mid-divide: abandons DIV_BUSY, returns to RUN, no div_err.
// TESTING
//  Reset: rst_n=0 2 cycles -> pc_write=0, ctrl_bubble_sel=1, ifid_flush=1,
//   stall_cnt=0; rst_n=1 with no hazards -> pc_write=1, stall_cnt stays 0.
//  Load-use: idex_memread=1, idex_rd=5, ifid_rs2=5, use_rs2=1 -> 1 cycle
//   pc_write=0, ifid_write=0, bubble_sel=1; stall_cnt=1; rd=0 case -> no stall.
//  Redirect + load-use same cycle -> ifid_flush=1, bubble_sel=1, pc_write=1, no stall.
//  Divide: ex_is_div=1, div_done 33 cycles later -> div_start pulse once, ex_hold=1
//   for 33 cycles, then exmem_bubble=0 with done, back to RUN; stall_cnt=34.
//  Watchdog: DIV_MAX_CYC=8, div_done never -> div_err pulse in 8th DIV_BUSY
//   cycle, exmem_bubble=1, RUN next; done on 8th cycle -> no div_err.
//  Reset asserted 3 cycles into DIV_BUSY -> state RUN, no div_err, stall_cnt=0.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard/stall controller.
// The master side is the pipeline; the slave side is the controller.
interface hazard_stall_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] ifid_rs1;
    logic [REG_W-1:0] ifid_rs2;
    logic             ifid_use_rs1;
    logic             ifid_use_rs2;
    logic [REG_W-1:0] idex_rd;
    logic             idex_memread;
    logic             ex_is_div;
    logic             div_done;
    logic             ex_redirect;

    logic             pc_write;
    logic             ifid_write;
    logic             ctrl_bubble_sel;
    logic             ifid_flush;
    logic             ex_hold;
    logic             exmem_bubble;
    logic             div_start;
    logic             div_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
               idex_rd, idex_memread, ex_is_div, div_done, ex_redirect,
        input  pc_write, ifid_write, ctrl_bubble_sel, ifid_flush,
               ex_hold, exmem_bubble, div_start, div_err, stall_cnt
    );

    modport slave (
        input  ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
               idex_rd, idex_memread, ex_is_div, div_done, ex_redirect,
        output pc_write, ifid_write, ctrl_bubble_sel, ifid_flush,
               ex_hold, exmem_bubble, div_start, div_err, stall_cnt
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, multi-cycle divide sequencing
// with a watchdog, wrong-path squash on redirect, and a saturating stall counter.
module hazard_stall_ctrl #(
    parameter int REG_W       = 5,
    parameter int DIV_MAX_CYC = 34,
    parameter int CNT_W       = 16
) (
    input logic                clk,
    input logic                rst_n,
    hazard_stall_ctrl_if.slave bus
);
    localparam int WD_W = $clog2(DIV_MAX_CYC + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(DIV_MAX_CYC - 1);

    typedef enum logic {RUN, DIV_BUSY} state_t;

    state_t           state;
    state_t           next_state;
    logic [WD_W-1:0]  wdog;
    logic [CNT_W-1:0] stall_cnt;
    logic             lu_haz;

    logic pc_write, ifid_write, ctrl_bubble_sel, ifid_flush;
    logic ex_hold, exmem_bubble, div_start, div_err;

    assign lu_haz = bus.idex_memread && (bus.idex_rd != '0) &&
                    ((bus.ifid_use_rs1 && (bus.ifid_rs1 == bus.idex_rd)) ||
                     (bus.ifid_use_rs2 && (bus.ifid_rs2 == bus.idex_rd)));

    // Watchdog is held at zero in RUN so it starts from zero on the first busy cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            wdog      <= '0;
            stall_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == DIV_BUSY) begin
                wdog <= wdog + 1'b1;
            end else begin
                wdog <= '0;
            end
            if (!pc_write && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        next_state      = state;
        pc_write        = 1'b1;
        ifid_write      = 1'b1;
        ctrl_bubble_sel = 1'b0;
        ifid_flush      = 1'b0;
        ex_hold         = 1'b0;
        exmem_bubble    = 1'b0;
        div_start       = 1'b0;
        div_err         = 1'b0;

        case (state)
            RUN: begin
                if (bus.ex_redirect) begin
                    ifid_flush      = 1'b1;
                    ctrl_bubble_sel = 1'b1;
                end else if (bus.ex_is_div) begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    ex_hold      = 1'b1;
                    exmem_bubble = 1'b1;
                    div_start    = 1'b1;
                    next_state   = DIV_BUSY;
                end else if (lu_haz) begin
                    pc_write        = 1'b0;
                    ifid_write      = 1'b0;
                    ctrl_bubble_sel = 1'b1;
                end
            end
            DIV_BUSY: begin
                // The divide owns EX here, so redirects and load-use are not looked at.
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                ex_hold      = 1'b1;
                exmem_bubble = 1'b1;
                if (bus.div_done) begin
                    ex_hold      = 1'b0;
                    exmem_bubble = 1'b0;
                    next_state   = RUN;
                end else if (wdog == WD_LIMIT) begin
                    div_err    = 1'b1;
                    ex_hold    = 1'b0;
                    next_state = RUN;
                end
            end
            default: next_state = RUN;
        endcase

        if (!rst_n) begin
            next_state      = RUN;
            pc_write        = 1'b0;
            ifid_write      = 1'b0;
            ctrl_bubble_sel = 1'b1;
            ifid_flush      = 1'b1;
            ex_hold         = 1'b0;
            exmem_bubble    = 1'b1;
            div_start       = 1'b0;
            div_err         = 1'b0;
        end
    end

    assign bus.pc_write        = pc_write;
    assign bus.ifid_write      = ifid_write;
    assign bus.ctrl_bubble_sel = ctrl_bubble_sel;
    assign bus.ifid_flush      = ifid_flush;
    assign bus.ex_hold         = ex_hold;
    assign bus.exmem_bubble    = exmem_bubble;
    assign bus.div_start       = div_start;
    assign bus.div_err         = div_err;
    assign bus.stall_cnt       = stall_cnt;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: a default-parameter instance plus a
// short-watchdog instance (DIV_MAX_CYC=8) share the same stimulus.
module tb_hazard_stall_ctrl;
    // Flag order: pc_write ifid_write bubble_sel ifid_flush ex_hold exmem_bubble div_start div_err
    localparam logic [7:0] F_RESET  = 8'b0011_0100;
    localparam logic [7:0] F_NORMAL = 8'b1100_0000;
    localparam logic [7:0] F_LU     = 8'b0010_0000;
    localparam logic [7:0] F_REDIR  = 8'b1111_0000;
    localparam logic [7:0] F_DSTART = 8'b0000_1110;
    localparam logic [7:0] F_BUSY   = 8'b0000_1100;
    localparam logic [7:0] F_DONE   = 8'b0000_0000;
    localparam logic [7:0] F_ERR    = 8'b0000_0101;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(16)) bus ();
    hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(16)) wbus ();

    hazard_stall_ctrl #(.REG_W(5), .DIV_MAX_CYC(34), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave));
    hazard_stall_ctrl #(.REG_W(5), .DIV_MAX_CYC(8), .CNT_W(16)) dut_wd (
        .clk(clk), .rst_n(rst_n), .bus(wbus.slave));

    logic [23:0] obs;
    logic [7:0]  wobs;
    assign obs  = {bus.pc_write, bus.ifid_write, bus.ctrl_bubble_sel, bus.ifid_flush,
                   bus.ex_hold, bus.exmem_bubble, bus.div_start, bus.div_err, bus.stall_cnt};
    assign wobs = {wbus.pc_write, wbus.ifid_write, wbus.ctrl_bubble_sel, wbus.ifid_flush,
                   wbus.ex_hold, wbus.exmem_bubble, wbus.div_start, wbus.div_err};

    logic [23:0] sb[$];
    logic [7:0]  wsb[$];
    logic [15:0] cnt_m;
    int checks   = 0;
    int failures = 0;

    // Drives the same pipeline inputs into both instances.
    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                          input logic u2, input logic [4:0] rd, input logic mr,
                          input logic dv, input logic dn, input logic redir);
        bus.ifid_rs1 = rs1;      wbus.ifid_rs1 = rs1;
        bus.ifid_rs2 = rs2;      wbus.ifid_rs2 = rs2;
        bus.ifid_use_rs1 = u1;   wbus.ifid_use_rs1 = u1;
        bus.ifid_use_rs2 = u2;   wbus.ifid_use_rs2 = u2;
        bus.idex_rd = rd;        wbus.idex_rd = rd;
        bus.idex_memread = mr;   wbus.idex_memread = mr;
        bus.ex_is_div = dv;      wbus.ex_is_div = dv;
        bus.div_done = dn;       wbus.div_done = dn;
        bus.ex_redirect = redir; wbus.ex_redirect = redir;
    endtask

    // Queue the expected flags with the current modelled count, then advance the model.
    task automatic applyStimulus(input logic [7:0] f);
        sb.push_back({f, cnt_m});
        if (!rst_n) cnt_m = 16'd0;
        else if (!f[7] && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
    endtask

    task automatic test_reset();
        logic [23:0] e;
        rst_n = 1'b0;
        set_in(5'd1, 5'd1, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        cnt_m = 16'd0;
        #1 rst_n = 1'b0;
        applyStimulus(F_RESET);
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL reset_hold: got flags=%b cnt=%0d, expected flags=%b cnt=%0d", obs[23:16], obs[15:0], e[23:16], e[15:0]);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            rst_n = 1'b1;
            set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            applyStimulus(F_NORMAL);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL reset_release: got flags=%b cnt=%0d, expected flags=%b cnt=%0d", obs[23:16], obs[15:0], e[23:16], e[15:0]);
            end
        end
    endtask

    task automatic test_load_use();
        logic [23:0] e;
        logic [4:0]  rs1v[5] = '{5'd0, 5'd0, 5'd7, 5'd0, 5'd0};
        logic [4:0]  rs2v[5] = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5};
        logic        u1v[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        u2v[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [4:0]  rdv[5]  = '{5'd5, 5'd0, 5'd7, 5'd0, 5'd5};
        logic        mrv[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0]  fv[5]   = '{F_LU, F_NORMAL, F_LU, F_NORMAL, F_NORMAL};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            set_in(rs1v[i], rs2v[i], u1v[i], u2v[i], rdv[i], mrv[i], 1'b0, 1'b0, 1'b0);
            applyStimulus(fv[i]);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL load_use[%0d]: got flags=%b cnt=%0d, expected flags=%b cnt=%0d", i, obs[23:16], obs[15:0], e[23:16], e[15:0]);
            end
        end
    endtask

    task automatic test_redirect();
        logic [23:0] e;
        logic       dvv[3] = '{1'b0, 1'b1, 1'b0};
        logic       rdr[3] = '{1'b1, 1'b1, 1'b0};
        logic [7:0] fv[3]  = '{F_REDIR, F_REDIR, F_NORMAL};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            set_in(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, dvv[i], 1'b0, rdr[i]);
            if (i == 2) set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            applyStimulus(fv[i]);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL redirect[%0d]: got flags=%b cnt=%0d, expected flags=%b cnt=%0d", i, obs[23:16], obs[15:0], e[23:16], e[15:0]);
            end
        end
    endtask

    task automatic test_divide();
        logic [23:0] e;
        logic [15:0] start_cnt;
        start_cnt = cnt_m;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk); #1;
            if (i == 0)       begin set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); applyStimulus(F_DSTART); end
            else if (i < 33)  begin set_in(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1); applyStimulus(F_BUSY);   end
            else if (i == 33) begin set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0); applyStimulus(F_DONE);   end
            else              begin set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); applyStimulus(F_NORMAL); end
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL divide[%0d]: got flags=%b cnt=%0d, expected flags=%b cnt=%0d", i, obs[23:16], obs[15:0], e[23:16], e[15:0]);
            end
        end
        checks++;
        if (bus.stall_cnt - start_cnt !== 16'd34) begin
            failures++;
            $display("FAIL divide_stall_cycles: got %0d, expected 34", bus.stall_cnt - start_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] e;
        logic       dvv[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       dnv[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] fv[6]  = '{F_DSTART, F_BUSY, F_DONE, F_DSTART, F_DONE, F_NORMAL};
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, dvv[i], dnv[i], 1'b0);
            applyStimulus(fv[i]);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL back_to_back[%0d]: got flags=%b cnt=%0d, expected flags=%b cnt=%0d", i, obs[23:16], obs[15:0], e[23:16], e[15:0]);
            end
        end
    endtask

    // Only the DIV_MAX_CYC=8 instance is checked here.
    task automatic test_watchdog();
        logic [7:0] e;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                if (i == 0)      begin set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); wsb.push_back(F_DSTART); end
                else if (i < 8)  begin set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); wsb.push_back(F_BUSY);   end
                else if (i == 8) begin
                    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, p == 1, 1'b0);
                    wsb.push_back(p == 1 ? F_DONE : F_ERR);
                end
                else             begin set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); wsb.push_back(F_NORMAL); end
                @(negedge clk);
                e = wsb.pop_front(); checks++;
                if (wobs !== e) begin
                    failures++;
                    $display("FAIL watchdog[%0d][%0d]: got flags=%b, expected flags=%b", p, i, wobs, e);
                end
            end
        end
    endtask

    task automatic test_reset_mid_div();
        logic [23:0] e;
        logic [7:0]  w;
        @(posedge clk); #1;
        rst_n = 1'b0;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        cnt_m = 16'd0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            rst_n = (i != 4);
            set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, i < 5, 1'b0, 1'b0);
            if (i == 0)     applyStimulus(F_DSTART);
            else if (i < 4) applyStimulus(F_BUSY);
            else if (i == 4) applyStimulus(F_RESET);
            else            applyStimulus(F_NORMAL);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL reset_mid_div[%0d]: got flags=%b cnt=%0d, expected flags=%b cnt=%0d", i, obs[23:16], obs[15:0], e[23:16], e[15:0]);
            end
        end
        w = wobs; checks++;
        if (w !== F_NORMAL) begin
            failures++;
            $display("FAIL reset_mid_div_wd: got flags=%b, expected flags=%b", w, F_NORMAL);
        end
    endtask

    initial begin
        cnt_m = 16'd0;
        test_reset();
        test_load_use();
        test_redirect();
        test_divide();
        test_back_to_back();
        test_watchdog();
        test_reset_mid_div();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
